// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: FSM state
// encodings, nibble size and the operand-width legality check.
package cla_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Operands are processed a nibble per pass; at least two passes are needed.
    function automatic bit width_ok(input int unsigned width);
        return (width >= 8) && ((width % NIBBLE) == 0);
    endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry lookahead slice: generate/propagate terms with a fully
// flattened carry chain, so every carry is two gate levels from the inputs.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder: one cla4 slice is reused WIDTH/4 times, LS nibble
// first, with the inter-nibble carry held in a register. valid/ready on both
// sides; a result is held until consumed.
// Optional feature macro: CLA_SEQ_SUB_EN adds the 'sub' input (a - b) and the
// 'ovf' signed-overflow output.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / NIBBLE;
    localparam int unsigned CNT_W  = $clog2(NSLICE);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             co_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0]       nib_s;
    logic             nib_co;
    logic             last_nib;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    cla4 u_cla4 (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    assign last_nib = (cnt_q == CNT_W'(NSLICE - 1));

`ifdef CLA_SEQ_SUB_EN
    logic ovf_q;

    // Subtraction is a + ~b + 1; the caller's ci is ignored in that mode.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : ci;
    assign ovf        = ovf_q;
`else
    assign b_load     = b;
    assign carry_load = ci;
`endif

    // FSM, nibble counter, operand/sum shift registers and registered handshakes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            co_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q    <= StRun;
                        a_q        <= a;
                        b_q        <= b_load;
                        carry_q    <= carry_load;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    // Sum nibbles enter at the top so the LS nibble lands at bit 0 last.
                    s_q     <= {nib_s, s_q[WIDTH-1:NIBBLE]};
                    a_q     <= {{NIBBLE{1'b0}}, a_q[WIDTH-1:NIBBLE]};
                    b_q     <= {{NIBBLE{1'b0}}, b_q[WIDTH-1:NIBBLE]};
                    carry_q <= nib_co;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_nib) begin
                        state_q     <= StDone;
                        co_q        <= nib_co;
                        out_valid_q <= 1'b1;
`ifdef CLA_SEQ_SUB_EN
                        // Operands agree in sign but the sum's sign differs.
                        ovf_q <= (a_q[3] == b_q[3]) && (nib_s[3] != a_q[3]);
`endif
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign s         = s_q;
    assign co        = co_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=32). Define CLA_SEQ_SUB_EN for
// both RTL and bench to include the subtraction vectors.
module tb_cla_seq_adder;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             busy;

    int n_checks;
    int n_errors;
    int edge_cnt;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .busy      (busy)
    );

`ifndef CLA_SEQ_SUB_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) to be accepted, then wait (bounded) for out_valid.
    // lat counts edges from the accepting edge to out_valid; ir_seen flags in_ready while busy.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tci, input logic tsub,
                          output int lat, output int acc_edge, output logic ir_seen);
        int w;
        a        = ta;
        b        = tb_v;
        ci       = tci;
        sub      = tsub;
        in_valid = 1'b1;
        w        = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        tick();
        acc_edge = edge_cnt;
        in_valid = 1'b0;
        lat      = 0;
        ir_seen  = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) ir_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    initial begin
        int               lat;
        int               acc;
        int               prev_acc;
        logic             irs;
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic             vc [3];
        logic [WIDTH-1:0] vs [3];
        logic             vco [3];

        n_checks  = 0;
        n_errors  = 0;
        edge_cnt  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        check("rst_busy", busy, 0);

        // 1: all-ones + 1 wraps to zero with carry out
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, acc, irs);
        check("t1_latency", lat, 8);
        check("t1_out_valid", out_valid, 1);
        check("t1_s", s, 32'h0000_0000);
        check("t1_co", co, 1);
        check("t1_busy_done", busy, 1);
        check("t1_in_ready_done", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("t1_out_valid_drop", out_valid, 0);
        check("t1_in_ready_idle", in_ready, 1);
        out_ready = 1'b0;

        // 2: mixed operands with carry in; in_ready low throughout
        run_op(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, lat, acc, irs);
        check("t2_latency", lat, 8);
        check("t2_in_ready_low", irs, 0);
        check("t2_s", s, 32'h9999_999A);
        check("t2_co", co, 0);

        // 3: consumer stalls 5 cycles; a new request meanwhile is ignored
        a        = 32'h0000_0001;
        b        = 32'h0000_0001;
        ci       = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_out_valid", out_valid, 1);
            check("t3_hold_s", s, 32'h9999_999A);
            check("t3_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t3_out_valid_drop", out_valid, 0);
        check("t3_in_ready_idle", in_ready, 1);
        check("t3_s_kept", s, 32'h9999_999A);
        out_ready = 1'b0;
        tick();
        check("t3_no_accept", busy, 0);

        // 4: async reset during RUN at cnt=3 aborts immediately
        a        = 32'h0000_000F;
        b        = 32'h0000_0001;
        ci       = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t4_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t4_rst_in_ready", in_ready, 1);
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_s", s, 0);
        check("t4_rst_co", co, 0);
        check("t4_rst_busy", busy, 0);
        #2;
        reset_n = 1'b1;
        tick();
        run_op(32'd100, 32'd200, 1'b1, 1'b0, lat, acc, irs);
        check("t4_after_latency", lat, 8);
        check("t4_after_s", s, 32'd301);
        check("t4_after_co", co, 0);

        // 5: back-to-back with out_ready tied high
        out_ready = 1'b1;
        tick();
        va[0] = 32'hFFFF_0000; vb[0] = 32'h0000_FFFF; vc[0] = 1'b1;
        vs[0] = 32'h0000_0000; vco[0] = 1'b1;
        va[1] = 32'hDEAD_BEEF; vb[1] = 32'h1111_1111; vc[1] = 1'b0;
        vs[1] = 32'hEFBE_D000; vco[1] = 1'b0;
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vc[2] = 1'b1;
        vs[2] = 32'h8000_0001; vco[2] = 1'b0;
        prev_acc = 0;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], vc[k], 1'b0, lat, acc, irs);
            check("t5_latency", lat, 8);
            check("t5_s", s, vs[k]);
            check("t5_co", co, vco[k]);
            if (k > 0) check("t5_spacing", acc - prev_acc, 10);
            prev_acc = acc;
        end
        tick();
        out_ready = 1'b0;

`ifdef CLA_SEQ_SUB_EN
        // 6: subtraction and signed overflow
        run_op(32'd5, 32'd7, 1'b0, 1'b1, lat, acc, irs);
        check("t6_sub_s", s, 32'hFFFF_FFFE);
        check("t6_sub_co", co, 0);
        check("t6_sub_ovf", ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat, acc, irs);
        check("t6_ovf_s", s, 32'h7FFF_FFFF);
        check("t6_ovf_co", co, 1);
        check("t6_ovf", ovf, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
